// File: rtl/data_axi_bridge_pkg.sv
// Shared definitions for the data-side SRAM-to-AXI bridge: FSM states,
// fixed AXI field values, SRAM size encodings and the AXI size helper.
package data_axi_bridge_pkg;

    // Bridge FSM states; one outstanding transaction at a time.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Transaction ID used on AR, AW and W for all data-side traffic.
    localparam logic [3:0] DATA_AXI_ID    = 4'd1;

    // Single-beat incrementing bursts only.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    // SRAM-side transfer size encodings.
    localparam logic [1:0] SIZE_BYTE      = 2'd0;
    localparam logic [1:0] SIZE_HALF      = 2'd1;
    localparam logic [1:0] SIZE_WORD      = 2'd2;

    // AXI AxSIZE is the SRAM size zero-extended to three bits.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/data_axi_bridge_wstrb_gen.sv
// Byte-lane strobe decode for a single write beat from size and the low
// two address bits.
module wstrb_gen
    import data_axi_bridge_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] wstrb_o
);

    // Select the active byte lanes for byte, halfword or word writes.
    always_comb begin
        // NOTE: default assignment first so every path drives wstrb_o and no latch is inferred.
        wstrb_o = 4'b1111;
        case (size_i)
            SIZE_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
            SIZE_HALF: wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
            default:   wstrb_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/data_axi_bridge.sv
// Data-side SRAM-like to AXI bridge. Accepts one request in IDLE, issues a
// single-beat AXI read or write, and reports completion with a one-cycle
// data_ok pulse before returning to IDLE.
module data_axi_bridge
    import data_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    // SRAM-like request side
    input  logic        wrap_data_req,
    input  logic        wrap_data_wr,
    input  logic [1:0]  wrap_data_size,
    input  logic [31:0] wrap_data_addr,
    input  logic [31:0] wrap_data_wdata,
    output logic        wrap_data_addr_ok,
    output logic        wrap_data_data_ok,
    output logic [31:0] wrap_data_rdata,

    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    // AXI write address channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    // AXI write data channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    // AXI write response channel
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_e      state_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        data_ok_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic        aw_hs;
    logic        w_hs;
    logic        aw_done_d;
    logic        w_done_d;

    // Response IDs and error codes are deliberately ignored; a transaction
    // always completes normally whatever the slave reports.
    logic        unused_resp;
    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

    // Write-phase handshakes; AW and W complete independently and may land
    // in the same cycle, so the "done" view includes this cycle's handshake.
    assign aw_hs     = awvalid_q & awready;
    assign w_hs      = wvalid_q & wready;
    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q | w_hs;

    // Bridge FSM with registered channel controls and latched request fields.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            data_ok_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wrap_data_req && wrap_data_addr_ok) begin
                        wr_q    <= wrap_data_wr;
                        size_q  <= wrap_data_size;
                        addr_q  <= wrap_data_addr;
                        wdata_q <= wrap_data_wdata;
                        if (wrap_data_wr) begin
                            state_q   <= ST_WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        rready_q  <= 1'b0;
                        rdata_q   <= rdata;
                        data_ok_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_WR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        bready_q  <= 1'b0;
                        rdata_q   <= 32'd0;
                        data_ok_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    data_ok_q <= 1'b0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Request side: accept only in IDLE and never while reset is held.
    assign wrap_data_addr_ok = (state_q == ST_IDLE) && !reset;
    assign wrap_data_data_ok = data_ok_q & ~reset;
    assign wrap_data_rdata   = rdata_q;

    // Read address channel
    assign arid    = DATA_AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = axi_size(size_q);
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q & ~reset;
    assign rready  = rready_q & ~reset;

    // Write address channel
    assign awid    = DATA_AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = axi_size(size_q);
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q & ~reset;

    // Write data channel
    assign wid     = DATA_AXI_ID;
    assign wdata   = wdata_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q & ~reset;
    assign bready  = bready_q & ~reset;

    wstrb_gen u_wstrb_gen (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .wstrb_o   (wstrb)
    );

    // The write flag is kept for debug visibility of the latched request.
    logic unused_wr;
    assign unused_wr = wr_q;

endmodule

// File: doc/data_axi_bridge.md
DATA_AXI_BRIDGE -- requirements
Module: data_axi_bridge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 wrap_data_req/wr/size/addr/wdata  in  1/1/2/32/32  SRAM-like request from the data-side 2x1 mux.
REQ-005 wrap_data_addr_ok/data_ok  out  1/1  request accepted / response complete.
REQ-006 wrap_data_rdata  out  32  read data, valid with data_ok.
REQ-007 arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1; arready in 1.
REQ-008 rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready out 1.
REQ-009 awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1; awready in 1.
REQ-010 wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready in 1.
REQ-011 bid/bresp/bvalid  in  4/2/1; bready out 1.

Function
REQ-012 The block SHALL hold at most one outstanding transaction.
REQ-013 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR (AW and W), WR_RESP, DONE.
REQ-014 wrap_data_addr_ok SHALL equal (state==IDLE), combinationally.
REQ-015 req&&addr_ok SHALL latch wr/size/addr/wdata and move to RD_ADDR (wr=0) or WR (wr=1) next cycle.
REQ-016 RD_ADDR: arvalid=1 with latched fields; on arvalid&&arready go to RD_DATA.
REQ-017 RD_DATA: rready=1; on rvalid&&rready register rdata and go to DONE.
REQ-018 WR: awvalid and wvalid asserted together; each drops independently after its own handshake (aw_done, w_done flags); when both done (incl. same cycle) go to WR_RESP.
REQ-019 WR_RESP: bready=1; on bvalid&&bready go to DONE.
REQ-020 DONE: data_ok=1 for exactly one cycle, rdata held (0 after write), then IDLE.
REQ-021 Fixed fields: arid=awid=wid=4'd1, arlen=awlen=0, arburst=awburst=2'b01, wlast=1, lock/cache/prot=0.
REQ-022 arsize/awsize SHALL be {1'b0,size}; araddr/awaddr SHALL be the latched address unmodified.
REQ-023 wstrb: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<{addr[1],1'b0}; size 2/3 -> 4'b1111.
REQ-024 wdata SHALL pass the latched wdata unchanged.
REQ-025 rresp/bresp errors and rid/bid values SHALL be ignored; completion proceeds normally.
REQ-026 Minimum read latency: req in cycle 0 -> data_ok in cycle 3 with arready and rvalid tied 1.
REQ-027 Request inputs outside IDLE SHALL be ignored; latched fields SHALL stay stable until DONE.

Reset
REQ-028 Reset SHALL force IDLE, clear aw_done/w_done, latched fields and rdata to 0.
REQ-029 During reset all valid/ready outputs and data_ok SHALL be 0; addr_ok SHALL be 0 while reset is high.
REQ-030 Reset mid-transaction SHALL abandon it without data_ok; no retry after release.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, AXI burst/size constants and the data-side ID constant.
REQ-032 wstrb decode SHALL be a sub-module named wstrb_gen (size, addr[1:0] -> wstrb).

Verification
REQ-033 Read, arready/rvalid tied 1: req size 2 addr 0x1FC0_0004 -> arsize 3'b010, data_ok cycle 3, rdata=rdata bus value 0xDEAD_BEEF.
REQ-034 Byte write addr 0x8000_0003 wdata 0x7700_0000 -> wstrb 4'b1000, awsize 0, data_ok one cycle after bvalid handshake.
REQ-035 Write, awready 3 cycles before wready: awvalid drops after its handshake, wvalid stays until its own, single B accepted, one data_ok.
REQ-036 Back-to-back reqs held high: second addr_ok only after first DONE; two data_ok pulses, no overlap on AR/AW.
REQ-037 Reset asserted in RD_DATA with rvalid=0 -> next cycle IDLE, all valids 0, no data_ok; fresh read completes normally.
REQ-038 bresp=2'b10 on write -> data_ok still pulses once, FSM returns to IDLE.
